// File: rtl/ppg_slot_sequencer.sv
`default_nettype none
// ============================================================================
// ppg_slot_sequencer : RED -> IR -> DARK optical slot sequencer with per-slot
//                      settle blanking, ADC window averaging, frame publish.
// Revision: 1.0
// ============================================================================
module ppg_slot_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int SAMPLE_LOG2   = 3
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [6:0] red_dc_comp,
  input  logic [3:0] red_pga,
  input  logic [6:0] ir_dc_comp,
  input  logic [3:0] ir_pga,
  input  logic [3:0] led_drive_cfg,
  input  logic [7:0] ADC,
  output logic       LED_RED,
  output logic       LED_IR,
  output logic [3:0] LED_DRIVE,
  output logic [6:0] DC_Comp,
  output logic [3:0] PGA_Gain,
  output logic [7:0] RED_ADC_Value,
  output logic [7:0] IR_ADC_Value,
  output logic [7:0] DARK_ADC_Value,
  output logic       frame_valid,
  output logic       busy
);

  localparam int         ACC_W        = 8 + SAMPLE_LOG2;
  localparam logic [4:0] SETTLE_LAST  = 5'(SETTLE_CYCLES - 1);
  localparam logic [4:0] SAMPLE_LAST  = 5'((1 << SAMPLE_LOG2) - 1);
  localparam logic [6:0] IDLE_DC_COMP = 7'd64;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RED_SETTLE  = 3'd1,
    RED_SAMPLE  = 3'd2,
    IR_SETTLE   = 3'd3,
    IR_SAMPLE   = 3'd4,
    DARK_SETTLE = 3'd5,
    DARK_SAMPLE = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [7:0]       slot_avg;
  logic             capture;

  logic [6:0] red_dc_q, red_dc_d, ir_dc_q, ir_dc_d;
  logic [3:0] red_pga_q, red_pga_d, ir_pga_q, ir_pga_d, drive_q, drive_d;
  logic [7:0] red_slot_q, red_slot_d, ir_slot_q, ir_slot_d;

  logic       led_red_q, led_red_d, led_ir_q, led_ir_d;
  logic [3:0] led_drive_q, led_drive_d, pga_gain_q, pga_gain_d;
  logic [6:0] dc_comp_q, dc_comp_d;
  logic [7:0] red_val_q, red_val_d, ir_val_q, ir_val_d, dark_val_q, dark_val_d;
  logic       frame_valid_q, frame_valid_d, busy_q, busy_d;

  // Window sum including the current edge's sample; max 255 * 2^N fits ACC_W.
  always_comb begin
    acc_sum  = acc_q + ACC_W'(ADC);
    slot_avg = 8'(acc_sum >> SAMPLE_LOG2);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    capture       = 1'b0;
    red_slot_d    = red_slot_q;
    ir_slot_d     = ir_slot_q;
    red_val_d     = red_val_q;
    ir_val_d      = ir_val_q;
    dark_val_d    = dark_val_q;
    frame_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 5'd0;
        acc_d = '0;
        if (enable) begin
          capture = 1'b1;
          state_d = RED_SETTLE;
        end
      end

      RED_SETTLE, IR_SETTLE, DARK_SETTLE: begin
        acc_d = '0;
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = 5'd0;
          case (state_q)
            RED_SETTLE: state_d = RED_SAMPLE;
            IR_SETTLE:  state_d = IR_SAMPLE;
            default:    state_d = DARK_SAMPLE;
          endcase
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      RED_SAMPLE, IR_SAMPLE, DARK_SAMPLE: begin
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d = 5'd0;
          acc_d = '0;
          case (state_q)
            RED_SAMPLE: begin
              red_slot_d = slot_avg;
              state_d    = IR_SETTLE;
            end
            IR_SAMPLE: begin
              ir_slot_d = slot_avg;
              state_d   = DARK_SETTLE;
            end
            default: begin
              // All three values move together so readers never see a mixed frame.
              red_val_d     = red_slot_q;
              ir_val_d      = ir_slot_q;
              dark_val_d    = slot_avg;
              frame_valid_d = 1'b1;
              if (enable) begin
                capture = 1'b1;
                state_d = RED_SETTLE;
              end else begin
                state_d = IDLE;
              end
            end
          endcase
        end else begin
          cnt_d = cnt_q + 5'd1;
          acc_d = acc_sum;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
        acc_d   = '0;
      end
    endcase
  end

  always_comb begin
    red_dc_d  = red_dc_q;
    red_pga_d = red_pga_q;
    ir_dc_d   = ir_dc_q;
    ir_pga_d  = ir_pga_q;
    drive_d   = drive_q;
    if (capture) begin
      red_dc_d  = red_dc_comp;
      red_pga_d = red_pga;
      ir_dc_d   = ir_dc_comp;
      ir_pga_d  = ir_pga;
      drive_d   = led_drive_cfg;
    end
  end

  // Outputs are decoded from the state being entered so they switch on that edge.
  always_comb begin
    led_red_d   = 1'b0;
    led_ir_d    = 1'b0;
    led_drive_d = drive_d;
    dc_comp_d   = red_dc_d;
    pga_gain_d  = red_pga_d;
    busy_d      = 1'b1;
    case (state_d)
      RED_SETTLE, RED_SAMPLE: led_red_d = 1'b1;
      IR_SETTLE, IR_SAMPLE: begin
        led_ir_d   = 1'b1;
        dc_comp_d  = ir_dc_d;
        pga_gain_d = ir_pga_d;
      end
      DARK_SETTLE, DARK_SAMPLE: ;
      default: begin
        led_drive_d = 4'd0;
        dc_comp_d   = IDLE_DC_COMP;
        pga_gain_d  = 4'd0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 5'd0;
      acc_q         <= '0;
      red_dc_q      <= 7'd0;
      red_pga_q     <= 4'd0;
      ir_dc_q       <= 7'd0;
      ir_pga_q      <= 4'd0;
      drive_q       <= 4'd0;
      red_slot_q    <= 8'd0;
      ir_slot_q     <= 8'd0;
      led_red_q     <= 1'b0;
      led_ir_q      <= 1'b0;
      led_drive_q   <= 4'd0;
      dc_comp_q     <= IDLE_DC_COMP;
      pga_gain_q    <= 4'd0;
      red_val_q     <= 8'd0;
      ir_val_q      <= 8'd0;
      dark_val_q    <= 8'd0;
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_q         <= acc_d;
      red_dc_q      <= red_dc_d;
      red_pga_q     <= red_pga_d;
      ir_dc_q       <= ir_dc_d;
      ir_pga_q      <= ir_pga_d;
      drive_q       <= drive_d;
      red_slot_q    <= red_slot_d;
      ir_slot_q     <= ir_slot_d;
      led_red_q     <= led_red_d;
      led_ir_q      <= led_ir_d;
      led_drive_q   <= led_drive_d;
      dc_comp_q     <= dc_comp_d;
      pga_gain_q    <= pga_gain_d;
      red_val_q     <= red_val_d;
      ir_val_q      <= ir_val_d;
      dark_val_q    <= dark_val_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
    end
  end

  assign LED_RED        = led_red_q;
  assign LED_IR         = led_ir_q;
  assign LED_DRIVE      = led_drive_q;
  assign DC_Comp        = dc_comp_q;
  assign PGA_Gain       = pga_gain_q;
  assign RED_ADC_Value  = red_val_q;
  assign IR_ADC_Value   = ir_val_q;
  assign DARK_ADC_Value = dark_val_q;
  assign frame_valid    = frame_valid_q;
  assign busy           = busy_q;

endmodule
`default_nettype wire

// File: doc/ppg_slot_sequencer.md
# ppg_slot_sequencer

Time-slot sequencer for the pulse-oximeter optical front end. Once the settings search has produced per-channel DC compensation and PGA gain, this block drives LED_RED/LED_IR, DC_Comp, PGA_Gain and LED_DRIVE through a repeating RED → IR → DARK frame. In each slot it discards the analog settling period, averages the ADC over a fixed window, and publishes one coherent set of RED/IR/ambient samples per frame.

## Interface
Parameters:
- SETTLE_CYCLES, 2: cycles per slot with ADC ignored after LED/setting change (1..15)
- SAMPLE_LOG2, 3: averaging window of 2^SAMPLE_LOG2 cycles per slot (0..4)

Ports (reset rst_n, asynchronous, active-low; clock CLK):
- CLK  in  1  system clock, 1 kHz
- rst_n  in  1  async active-low reset
- enable  in  1  run frames while high
- red_dc_comp  in  7  RED DC compensation setting
- red_pga  in  4  RED PGA gain setting
- ir_dc_comp  in  7  IR DC compensation setting
- ir_pga  in  4  IR PGA gain setting
- led_drive_cfg  in  4  LED drive current setting
- ADC  in  8  converter output, sampled on rising CLK
- LED_RED  out  1  RED LED on
- LED_IR  out  1  IR LED on
- LED_DRIVE  out  4  applied LED drive
- DC_Comp  out  7  applied DC compensation
- PGA_Gain  out  4  applied PGA gain
- RED_ADC_Value  out  8  RED slot average
- IR_ADC_Value  out  8  IR slot average
- DARK_ADC_Value  out  8  ambient (both LEDs off) average
- frame_valid  out  1  one-cycle pulse: all three values updated
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, RED_SETTLE, RED_SAMPLE, IR_SETTLE, IR_SAMPLE, DARK_SETTLE, DARK_SAMPLE.
- IDLE: LEDs off, DC_Comp=64, PGA_Gain=0, LED_DRIVE=0. If enable is high at an edge, capture all five settings inputs into shadow registers and go to RED_SETTLE.
- Settings are used only from the shadow registers. Input changes mid-frame take effect at the next frame start.
- RED_*: LED_RED=1, LED_IR=0, DC_Comp/PGA_Gain = RED shadows.
- IR_*: LED_IR=1, LED_RED=0, IR shadows.
- DARK_*: both LEDs off, RED shadows applied.
- LED_DRIVE = shadow drive in all non-IDLE states.
- *_SETTLE: count SETTLE_CYCLES cycles. ADC is ignored. Then go to the matching *_SAMPLE.
- *_SAMPLE:
  - Accumulate ADC on each of 2^SAMPLE_LOG2 edges into an accumulator of width 8+SAMPLE_LOG2, cleared on SAMPLE entry. The accumulator cannot overflow.
  - On the last edge, store (acc+ADC)>>SAMPLE_LOG2 (truncating) into an internal slot register.
  - Exits: RED→IR_SETTLE, IR→DARK_SETTLE.
- DARK_SAMPLE end:
  - Copy all three slot results to RED/IR/DARK_ADC_Value simultaneously and pulse frame_valid.
  - If enable is high, recapture the shadows and go to RED_SETTLE (back-to-back frames, no gap). Otherwise go to IDLE.
- Enable low mid-frame: the current frame completes and publishes, then the block goes to IDLE. There is no abort.
- Published values hold until the next frame end. Outputs never show partial frames.

## Timing
- Reset (async, immediate): state IDLE, all counters/accumulators 0, LED_RED=LED_IR=0, LED_DRIVE=0, DC_Comp=64, PGA_Gain=0, all *_ADC_Value=0, frame_valid=0, busy=0.
- Reset mid-frame discards the partial frame; no frame_valid is produced.
- All outputs are registered and change on the edge that enters the state.
- Slot length S = SETTLE_CYCLES + 2^SAMPLE_LOG2; frame = 3S cycles (default 30 ms).
- With enable seen at edge 0:
  - RED_SETTLE occupies cycles 1..SETTLE_CYCLES.
  - First RED sample at the edge ending cycle SETTLE_CYCLES+1.
  - frame_valid is high for cycle 3S+1 (edge 3S) only.
  - Next frame's RED_SETTLE also starts in cycle 3S+1.
- Continuous enable: exactly one frame_valid per 3S cycles.

## Test plan
- Defaults; ADC=100 during RED, 150 during IR, 20 during DARK → at cycle 31: RED=100, IR=150, DARK=20, frame_valid single pulse; LED_RED high cycles 1–10, LED_IR high cycles 11–20.
- ADC ramps 0,1,2,… every cycle → RED value = mean of samples 3..10 (truncated); settle samples excluded; DARK_SAMPLE with ADC=255 throughout → DARK=255 (no overflow).
- Change red_dc_comp 10→90 during IR slot → DC_Comp stays 10 in DARK, becomes 90 at next RED_SETTLE.
- Drop enable at cycle 15 → frame completes, frame_valid at cycle 31, IDLE outputs (DC_Comp=64, LEDs off, busy=0) from cycle 31.
- Assert rst_n low at cycle 17 → all outputs at reset values immediately, no frame_valid; on release with enable high, a full new frame runs.
- SETTLE_CYCLES=1, SAMPLE_LOG2=0 → frame 6 cycles; each value equals the single ADC sample of its slot.
